// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: sequences fetch/decode/exec/mem/wb around one
// shared ALU and immediate generator, and counts retired instructions.
module multicycle_ctrl #(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          instr,
  input  logic                 imem_rdata_valid,
  input  logic                 dmem_ready,
  input  logic                 branch_taken,
  output logic                 imem_req,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic [1:0]           pc_sel,
  output logic [2:0]           imm_control,
  output logic                 alu_src_a,
  output logic                 alu_src_b,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic                 reg_we,
  output logic [1:0]           wb_sel,
  output logic                 csr_we,
  output logic                 halted,
  output logic [INSTRET_W-1:0] instret
);

  typedef enum logic [2:0] {S_RST, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;
  typedef enum logic [3:0] {K_LUI, K_AUIPC, K_JAL, K_JALR, K_BR, K_LD, K_ST, K_OPIMM, K_OP, K_SYS} kind_t;

  state_t state;
  kind_t  kind, dec_kind;
  logic   dec_legal, retire;
  logic [2:0] imm_sel;
  logic   instr_unused;

  // Only the opcode field steers control; the rest of the word feeds the datapath.
  assign instr_unused = ^instr[31:7];

  always_comb begin
    dec_legal = 1'b1;
    dec_kind  = K_OP;
    case (instr[6:0])
      7'b0110111: dec_kind = K_LUI;
      7'b0010111: dec_kind = K_AUIPC;
      7'b1101111: dec_kind = K_JAL;
      7'b1100111: dec_kind = K_JALR;
      7'b1100011: dec_kind = K_BR;
      7'b0000011: dec_kind = K_LD;
      7'b0100011: dec_kind = K_ST;
      7'b0010011: dec_kind = K_OPIMM;
      7'b0110011: dec_kind = K_OP;
      7'b1110011: dec_kind = K_SYS;
      default:    dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    case (kind)
      K_LUI, K_AUIPC: imm_sel = 3'b010;
      K_JAL:          imm_sel = 3'b100;
      K_BR:           imm_sel = 3'b011;
      K_ST:           imm_sel = 3'b001;
      K_SYS:          imm_sel = 3'b101;
      default:        imm_sel = 3'b000;
    endcase
  end

  assign retire = (state == S_EXEC && kind == K_BR) ||
                  (state == S_MEM && kind == K_ST && dmem_ready) ||
                  (state == S_WB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_RST;
      kind    <= K_OP;
      instret <= '0;
    end else begin
      case (state)
        S_RST:    state <= S_FETCH;
        S_FETCH:  if (imem_rdata_valid) state <= S_DECODE;
        S_DECODE: begin
          kind  <= dec_kind;
          state <= dec_legal ? S_EXEC : S_TRAP;
        end
        S_EXEC: begin
          if (kind == K_LD || kind == K_ST) state <= S_MEM;
          else if (kind == K_BR)            state <= S_FETCH;
          else                              state <= S_WB;
        end
        S_MEM:    if (dmem_ready) state <= (kind == K_ST) ? S_FETCH : S_WB;
        S_WB:     state <= S_FETCH;
        default:  state <= S_TRAP;
      endcase
      if (retire) instret <= instret + 1'b1;
    end
  end

  // Outputs decode straight from state so reset clears every request at once.
  always_comb begin
    imem_req    = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    pc_sel      = 2'b00;
    imm_control = 3'b000;
    alu_src_a   = 1'b0;
    alu_src_b   = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    reg_we      = 1'b0;
    wb_sel      = 2'b00;
    csr_we      = 1'b0;
    halted      = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_rdata_valid;
      end
      S_EXEC: begin
        imm_control = imm_sel;
        alu_src_a   = (kind == K_AUIPC) || (kind == K_JAL) || (kind == K_BR);
        alu_src_b   = (kind != K_OP);
        if (kind == K_BR) begin
          pc_we  = 1'b1;
          pc_sel = branch_taken ? 2'b01 : 2'b00;
        end
      end
      S_MEM: begin
        imm_control = imm_sel;
        dmem_req    = 1'b1;
        dmem_we     = (kind == K_ST);
        pc_we       = (kind == K_ST) && dmem_ready;
      end
      S_WB: begin
        imm_control = imm_sel;
        reg_we      = 1'b1;
        pc_we       = 1'b1;
        csr_we      = (kind == K_SYS);
        case (kind)
          K_LD:          wb_sel = 2'b01;
          K_JAL, K_JALR: wb_sel = 2'b10;
          K_SYS:         wb_sel = 2'b11;
          default:       wb_sel = 2'b00;
        endcase
        case (kind)
          K_JAL:   pc_sel = 2'b01;
          K_JALR:  pc_sel = 2'b10;
          default: pc_sel = 2'b00;
        endcase
      end
      S_TRAP:  halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle control vectors for each
// instruction class, wait states, async reset and instret wrap (INSTRET_W=4).
module tb_multicycle_ctrl;

  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [31:0]   instr = '0;
  logic          imem_rdata_valid = 1'b0, dmem_ready = 1'b0, branch_taken = 1'b0;
  logic          imem_req, ir_we, pc_we, alu_src_a, alu_src_b, dmem_req, dmem_we;
  logic          reg_we, csr_we, halted;
  logic [1:0]    pc_sel, wb_sel;
  logic [2:0]    imm_control;
  logic [IW-1:0] instret;
  logic [16:0]   outs;
  logic [IW-1:0] exp_ret;
  int            errs = 0, checks = 0;

  localparam logic [31:0] C_INS [6] = '{32'h000010B7, 32'h00001097, 32'h008000EF,
                                        32'h000080E7, 32'h002081B3, 32'h34009073};
  localparam logic [2:0]  C_IMM [6] = '{3'b010, 3'b010, 3'b100, 3'b000, 3'b000, 3'b101};
  localparam logic        C_SA  [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam logic        C_SB  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  localparam logic [1:0]  C_WB  [6] = '{2'd0, 2'd0, 2'd2, 2'd2, 2'd0, 2'd3};
  localparam logic [1:0]  C_PCS [6] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd0, 2'd0};
  localparam logic        C_CSR [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  multicycle_ctrl #(.INSTRET_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .imem_rdata_valid(imem_rdata_valid),
    .dmem_ready(dmem_ready), .branch_taken(branch_taken), .imem_req(imem_req),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .imm_control(imm_control),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .reg_we(reg_we), .wb_sel(wb_sel), .csr_we(csr_we),
    .halted(halted), .instret(instret)
  );

  always #5 clk = ~clk;

  assign outs = {imem_req, ir_we, pc_we, pc_sel, imm_control, alu_src_a, alu_src_b,
                 dmem_req, dmem_we, reg_we, wb_sel, csr_we, halted};

  // Expected control vector, same field order as outs.
  function automatic logic [16:0] mk(input logic imr, input logic irw, input logic pcw,
                                     input logic [1:0] pcs, input logic [2:0] imm,
                                     input logic sa, input logic sb, input logic dr,
                                     input logic dw, input logic rw, input logic [1:0] wb,
                                     input logic cw, input logic hl);
    return {imr, irw, pcw, pcs, imm, sa, sb, dr, dw, rw, wb, cw, hl};
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; imem_rdata_valid = 1'b0; dmem_ready = 1'b0; branch_taken = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    exp_ret = '0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (outs !== 17'h0) begin errs++; $display("FAIL reset_outs got=%h exp=%h", outs, 17'h0); end
    checks++; if (instret !== 4'h0) begin errs++; $display("FAIL reset_instret got=%h exp=0", instret); end
    tick();
    rst_n = 1'b1;
    tick();
    exp_ret = '0;
    checks++; if (outs !== mk(1,0,0,0,0,0,0,0,0,0,0,0,0)) begin errs++; $display("FAIL reset_to_fetch got=%h", outs); end
  endtask

  task automatic test_addi();
    instr = 32'h00500093; imem_rdata_valid = 1'b1; #1;
    checks++; if (outs !== mk(1,1,0,0,0,0,0,0,0,0,0,0,0)) begin errs++; $display("FAIL addi_fetch got=%h", outs); end
    tick();
    checks++; if (outs !== 17'h0) begin errs++; $display("FAIL addi_decode got=%h exp=0", outs); end
    tick();
    checks++; if (outs !== mk(0,0,0,0,3'b000,0,1,0,0,0,0,0,0)) begin errs++; $display("FAIL addi_exec got=%h", outs); end
    tick();
    checks++; if (outs !== mk(0,0,1,0,3'b000,0,0,0,0,1,2'b00,0,0)) begin errs++; $display("FAIL addi_wb got=%h", outs); end
    tick(); exp_ret++;
    checks++; if (!imem_req || instret !== exp_ret) begin errs++; $display("FAIL addi_retire req=%b instret=%h exp=%h", imem_req, instret, exp_ret); end
  endtask

  task automatic test_classes();
    for (int i = 0; i < 6; i++) begin
      instr = C_INS[i]; imem_rdata_valid = 1'b1;
      tick();
      checks++; if (outs !== 17'h0) begin errs++; $display("FAIL class%0d_decode got=%h exp=0", i, outs); end
      tick();
      checks++; if (outs !== mk(0,0,0,0,C_IMM[i],C_SA[i],C_SB[i],0,0,0,0,0,0)) begin errs++; $display("FAIL class%0d_exec got=%h", i, outs); end
      tick();
      checks++; if (outs !== mk(0,0,1,C_PCS[i],C_IMM[i],0,0,0,0,1,C_WB[i],C_CSR[i],0)) begin errs++; $display("FAIL class%0d_wb got=%h", i, outs); end
      tick(); exp_ret++;
      checks++; if (!imem_req || instret !== exp_ret) begin errs++; $display("FAIL class%0d_retire req=%b instret=%h exp=%h", i, imem_req, instret, exp_ret); end
    end
  endtask

  task automatic test_branch();
    for (int t = 1; t >= 0; t--) begin
      instr = 32'h00208463; imem_rdata_valid = 1'b1; branch_taken = t[0];
      tick();
      tick();
      checks++; if (outs !== mk(0,0,1,{1'b0,t[0]},3'b011,1,1,0,0,0,0,0,0)) begin errs++; $display("FAIL beq%0d_exec got=%h", t, outs); end
      tick(); exp_ret++;
      checks++; if (!imem_req || instret !== exp_ret) begin errs++; $display("FAIL beq%0d_3cyc req=%b instret=%h exp=%h", t, imem_req, instret, exp_ret); end
    end
    branch_taken = 1'b0;
  endtask

  task automatic test_store();
    instr = 32'h0020A223; imem_rdata_valid = 1'b1; dmem_ready = 1'b1;
    tick();
    tick();
    checks++; if (outs !== mk(0,0,0,0,3'b001,0,1,0,0,0,0,0,0)) begin errs++; $display("FAIL sw_exec got=%h", outs); end
    tick();
    checks++; if (outs !== mk(0,0,1,0,3'b001,0,0,1,1,0,0,0,0)) begin errs++; $display("FAIL sw_mem got=%h", outs); end
    tick(); exp_ret++;
    checks++; if (!imem_req || instret !== exp_ret) begin errs++; $display("FAIL sw_4cyc req=%b instret=%h exp=%h", imem_req, instret, exp_ret); end
    dmem_ready = 1'b0;
  endtask

  task automatic test_load_wait();
    instr = 32'h0000A103; imem_rdata_valid = 1'b1; dmem_ready = 1'b0;
    tick();
    tick();
    checks++; if (outs !== mk(0,0,0,0,3'b000,0,1,0,0,0,0,0,0)) begin errs++; $display("FAIL lw_exec got=%h", outs); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (outs !== mk(0,0,0,0,3'b000,0,0,1,0,0,0,0,0)) begin errs++; $display("FAIL lw_mem%0d got=%h", i, outs); end
      dmem_ready = (i == 3);
    end
    tick();
    dmem_ready = 1'b0;
    checks++; if (outs !== mk(0,0,1,0,3'b000,0,0,0,0,1,2'b01,0,0)) begin errs++; $display("FAIL lw_wb got=%h", outs); end
    tick(); exp_ret++;
    checks++; if (!imem_req || instret !== exp_ret) begin errs++; $display("FAIL lw_8cyc req=%b instret=%h exp=%h", imem_req, instret, exp_ret); end
  endtask

  task automatic test_fetch_wait();
    int n;
    instr = 32'h00500093; imem_rdata_valid = 1'b0; dmem_ready = 1'b1;
    #1;
    checks++; if (outs !== mk(1,0,0,0,0,0,0,0,0,0,0,0,0)) begin errs++; $display("FAIL fwait_hold got=%h", outs); end
    tick(); tick();
    imem_rdata_valid = 1'b1; #1;
    checks++; if (ir_we !== 1'b1) begin errs++; $display("FAIL fwait_irwe got=%b exp=1", ir_we); end
    n = 2;
    do begin tick(); n++; end while (!imem_req && n < 40);
    exp_ret++;
    checks++; if (n !== 6 || instret !== exp_ret) begin errs++; $display("FAIL fwait_6cyc cycles=%0d exp=6 instret=%h exp=%h", n, instret, exp_ret); end
    dmem_ready = 1'b0;
  endtask

  task automatic test_reset_mid_mem();
    instr = 32'h0000A103; imem_rdata_valid = 1'b1; dmem_ready = 1'b0;
    tick(); tick(); tick();
    checks++; if (dmem_req !== 1'b1) begin errs++; $display("FAIL midrst_pre got=%b exp=1", dmem_req); end
    rst_n = 1'b0; #1;
    checks++; if (outs !== 17'h0 || instret !== 4'h0) begin errs++; $display("FAIL midrst_async outs=%h instret=%h exp=0", outs, instret); end
    do_reset();
  endtask

  task automatic test_wrap();
    int n;
    instr = 32'h00500093; imem_rdata_valid = 1'b1;
    for (int k = 0; k < 15; k++) begin
      n = 0;
      do begin tick(); n++; end while (!imem_req && n < 40);
    end
    checks++; if (instret !== 4'hF) begin errs++; $display("FAIL wrap_full got=%h exp=f", instret); end
    n = 0;
    do begin tick(); n++; end while (!imem_req && n < 40);
    checks++; if (instret !== 4'h0 || n !== 4) begin errs++; $display("FAIL wrap_zero instret=%h exp=0 cycles=%0d", instret, n); end
  endtask

  task automatic test_trap();
    int bad = 0;
    instr = 32'hFFFFFFFF; imem_rdata_valid = 1'b1; dmem_ready = 1'b1;
    tick();
    checks++; if (outs !== 17'h0) begin errs++; $display("FAIL trap_decode got=%h exp=0", outs); end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++; if (outs !== mk(0,0,0,0,0,0,0,0,0,0,0,0,1)) begin errs++; bad++; if (bad < 3) $display("FAIL trap_hold%0d got=%h", i, outs); end
    end
    #2 rst_n = 1'b0; #1;
    checks++; if (halted !== 1'b0 || outs !== 17'h0) begin errs++; $display("FAIL trap_clear halted=%b outs=%h", halted, outs); end
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_classes();
    test_branch();
    test_store();
    test_load_wait();
    test_fetch_wait();
    test_reset_mid_mem();
    test_wrap();
    test_trap();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
